// File: rtl/eth_mmio_pkg.sv
// Shared register map, access-size encoding and TX playback states
// for the Ethernet controller host register responder.
package eth_mmio_pkg;

    localparam logic [15:0] TX_BUF_BASE = 16'h0800;
    localparam logic [15:0] TX_SEND     = 16'h1018;
    localparam logic [15:0] TX_READY    = 16'h101C;
    localparam logic [15:0] TX_SIZE     = 16'h1028;
    localparam logic [15:0] TX_PENDING  = 16'h1030;
    localparam logic [15:0] TX_INT_EN   = 16'h1034;

    typedef enum logic [1:0] {
        OP_B = 2'd0,
        OP_H = 2'd1,
        OP_W = 2'd2,
        OP_D = 2'd3
    } op_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } tx_state_e;

    // Byte-enable pattern of an access before it is shifted into its lane.
    function automatic logic [7:0] size_mask(input logic [1:0] op);
        unique case (op_size_e'(op))
            OP_B: return 8'h01;
            OP_H: return 8'h03;
            OP_W: return 8'h0F;
            OP_D: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/eth_tx_buffer_mem.sv
// TX packet buffer: 64-bit words, byte-masked write port and a
// registered read port that holds its output when not enabled.
module eth_tx_buffer_mem #(
    parameter int words_p  = 256,
    parameter int addr_w_p = 8
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [addr_w_p-1:0] wr_addr,
    input  logic [7:0]          wr_mask,
    input  logic [63:0]         wr_data,
    input  logic                rd_en,
    input  logic [addr_w_p-1:0] rd_addr,
    output logic [63:0]         rd_data
);

    logic [63:0] mem [words_p];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/eth_tx_mmio_responder.sv
// TX half of the host register responder: register decode, packet
// buffer writes and AXI-Stream playback toward the MAC.
module eth_tx_mmio_responder
    import eth_mmio_pkg::*;
#(
    parameter int buf_size_p       = 2048,
    parameter int axis_width_p     = 64,
    parameter int reg_addr_width_p = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [reg_addr_width_p-1:0] addr_i,
    input  logic                        write_en_i,
    input  logic                        read_en_i,
    input  logic [1:0]                  op_size_i,
    input  logic [axis_width_p-1:0]     write_data_i,
    output logic [axis_width_p-1:0]     read_data_o,
    output logic                        read_data_v_o,
    output logic [axis_width_p-1:0]     tx_axis_tdata_o,
    output logic [7:0]                  tx_axis_tkeep_o,
    output logic                        tx_axis_tvalid_o,
    output logic                        tx_axis_tlast_o,
    input  logic                        tx_axis_tready_i,
    output logic                        tx_interrupt_pending_o
);

    localparam int words_lp  = buf_size_p / 8;
    localparam int waddr_lp  = $clog2(words_lp);
    localparam int size_w_lp = $clog2(buf_size_p) + 1;
    localparam logic [reg_addr_width_p-1:0] span_lp =
        reg_addr_width_p'(buf_size_p - 1);

    tx_state_e state_r;
    logic [size_w_lp-1:0] size_r, size_nxt, wd, size_m1;
    logic [waddr_lp-1:0] ptr_r, last_r, rd_addr;
    logic [2:0] tail_r;
    logic pend_r, int_en_r, irq_r, rv_r;
    logic [axis_width_p-1:0] rdat_r, rdata, buf_wdata, mem_q;
    logic [7:0] smask, buf_mask;
    logic [3:0] lane;
    logic [31:0] reg_sel, mask32;
    logic misaligned, wr, rd, idle, in_buf;
    logic is_send, is_ready, is_size, is_pend, is_int_en;
    logic buf_we, size_we, send_ok, hs, is_last, mem_re;
    logic pend_set, pend_clr, pend_nxt, int_en_nxt;

    function automatic logic is_reg(input logic [reg_addr_width_p-1:0] a,
                                    input logic [15:0] r);
        return a[reg_addr_width_p-1:2] == r[reg_addr_width_p-1:2];
    endfunction

    always_comb begin
        smask = size_mask(op_size_i);
        misaligned = 1'b0;
        unique case (op_size_e'(op_size_i))
            OP_B: misaligned = 1'b0;
            OP_H: misaligned = addr_i[0];
            OP_W: misaligned = |addr_i[1:0];
            OP_D: misaligned = |addr_i[2:0];
        endcase
    end

    assign idle      = state_r == IDLE;
    assign wr        = write_en_i && !misaligned;
    assign rd        = read_en_i && !write_en_i;
    assign in_buf    = (addr_i & ~span_lp) == TX_BUF_BASE;
    assign is_send   = is_reg(addr_i, TX_SEND);
    assign is_ready  = is_reg(addr_i, TX_READY);
    assign is_size   = is_reg(addr_i, TX_SIZE);
    assign is_pend   = is_reg(addr_i, TX_PENDING);
    assign is_int_en = is_reg(addr_i, TX_INT_EN);

    // Register lanes are byte lanes within the addressed 32-bit word.
    assign lane      = 4'(smask << addr_i[1:0]);
    assign wd        = size_w_lp'(write_data_i[31:0] << {addr_i[1:0], 3'b000});
    assign buf_mask  = smask << addr_i[2:0];
    assign buf_wdata = write_data_i << {addr_i[2:0], 3'b000};
    assign buf_we    = wr && in_buf && idle;
    assign size_we   = wr && is_size && idle;
    assign send_ok   = wr && is_send && idle && size_r != '0
                       && size_r <= size_w_lp'(buf_size_p);
    assign size_m1   = size_r - 1'b1;

    always_comb begin
        size_nxt = size_r;
        for (int i = 0; i < size_w_lp; i++) begin
            if (lane[i/8]) size_nxt[i] = wd[i];
        end
    end

    assign pend_clr   = wr && is_pend && lane[0] && wd[0];
    assign int_en_nxt = (wr && is_int_en && lane[0]) ? wd[0] : int_en_r;
    assign pend_nxt   = pend_set | (pend_r & ~pend_clr);

    always_comb begin
        reg_sel = '0;
        unique case (1'b1)
            is_ready:  reg_sel[0] = idle;
            is_size:   reg_sel[size_w_lp-1:0] = size_r;
            is_pend:   reg_sel[0] = pend_r;
            is_int_en: reg_sel[0] = int_en_r;
            default:   ;
        endcase
        mask32 = '0;
        for (int b = 0; b < 4; b++) mask32[8*b +: 8] = {8{smask[b]}};
        rdata = '0;
        if (!misaligned) rdata[31:0] = (reg_sel >> {addr_i[1:0], 3'b000}) & mask32;
    end

    assign hs       = tx_axis_tvalid_o && tx_axis_tready_i;
    assign is_last  = ptr_r == last_r;
    assign pend_set = hs && is_last;
    // LOAD fetches beat 0; each non-final handshake prefetches the next beat.
    assign mem_re   = (state_r == LOAD) || (hs && !is_last);
    assign rd_addr  = (state_r == LOAD) ? '0 : ptr_r + 1'b1;

    eth_tx_buffer_mem #(
        .words_p  (words_lp),
        .addr_w_p (waddr_lp)
    ) buf_mem (
        .clk     (clk_i),
        .wr_en   (buf_we),
        .wr_addr (addr_i[waddr_lp+2:3]),
        .wr_mask (buf_mask),
        .wr_data (buf_wdata),
        .rd_en   (mem_re),
        .rd_addr (rd_addr),
        .rd_data (mem_q)
    );

    assign tx_axis_tvalid_o       = state_r == STREAM;
    assign tx_axis_tdata_o        = tx_axis_tvalid_o ? mem_q : '0;
    assign tx_axis_tlast_o        = tx_axis_tvalid_o && is_last;
    assign read_data_o            = rdat_r;
    assign read_data_v_o          = rv_r;
    assign tx_interrupt_pending_o = irq_r;

    always_comb begin
        tx_axis_tkeep_o = 8'h00;
        if (tx_axis_tvalid_o) begin
            if (!is_last || tail_r == 3'd0) tx_axis_tkeep_o = 8'hFF;
            else tx_axis_tkeep_o = (8'd1 << tail_r) - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            size_r   <= '0;
            ptr_r    <= '0;
            last_r   <= '0;
            tail_r   <= '0;
            pend_r   <= 1'b0;
            int_en_r <= 1'b0;
            irq_r    <= 1'b0;
            rv_r     <= 1'b0;
            rdat_r   <= '0;
        end else begin
            pend_r   <= pend_nxt;
            int_en_r <= int_en_nxt;
            irq_r    <= pend_nxt & int_en_nxt;
            rv_r     <= rd;
            rdat_r   <= rd ? rdata : '0;
            if (size_we) size_r <= size_nxt;
            unique case (state_r)
                IDLE: begin
                    if (send_ok) begin
                        state_r <= LOAD;
                        ptr_r   <= '0;
                        last_r  <= size_m1[size_w_lp-2:3];
                        tail_r  <= size_r[2:0];
                    end
                end
                LOAD: state_r <= STREAM;
                STREAM: begin
                    if (hs) begin
                        if (is_last) state_r <= IDLE;
                        else ptr_r <= ptr_r + 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_mmio_responder.sv
// Randomized bench for eth_tx_mmio_responder against a byte-level
// model of the TX buffer and its control registers.
module tb_eth_tx_mmio_responder;
    import eth_mmio_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] addr_i;
    logic        write_en_i, read_en_i;
    logic [1:0]  op_size_i;
    logic [63:0] write_data_i, read_data_o, tx_axis_tdata_o;
    logic        read_data_v_o;
    logic [7:0]  tx_axis_tkeep_o;
    logic        tx_axis_tvalid_o, tx_axis_tlast_o, tx_axis_tready_i;
    logic        tx_interrupt_pending_o;

    eth_tx_mmio_responder dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .addr_i                 (addr_i),
        .write_en_i             (write_en_i),
        .read_en_i              (read_en_i),
        .op_size_i              (op_size_i),
        .write_data_i           (write_data_i),
        .read_data_o            (read_data_o),
        .read_data_v_o          (read_data_v_o),
        .tx_axis_tdata_o        (tx_axis_tdata_o),
        .tx_axis_tkeep_o        (tx_axis_tkeep_o),
        .tx_axis_tvalid_o       (tx_axis_tvalid_o),
        .tx_axis_tlast_o        (tx_axis_tlast_o),
        .tx_axis_tready_i       (tx_axis_tready_i),
        .tx_interrupt_pending_o (tx_interrupt_pending_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    byte unsigned mem_m [2048];
    int  size_m;
    bit  pend_m, inten_m;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic model_wr(input logic [15:0] a, input logic [1:0] op,
                            input logic [63:0] d);
        int n, base, off;
        n = 1 << op;
        if (a % n != 0) return;
        if (a >= 16'h0800 && a < 16'h1000) begin
            for (int i = 0; i < n; i++) mem_m[a - 16'h0800 + i] = d[8*i +: 8];
            return;
        end
        base = a & ~3;
        off = a & 3;
        for (int i = 0; i < n && off + i < 4; i++) begin
            if (base == TX_SIZE) begin
                size_m = (size_m & ~(255 << 8*(off+i)))
                       | (int'(d[8*i +: 8]) << 8*(off+i));
                size_m &= 'hFFF;
            end
            if (base == TX_PENDING && off + i == 0 && d[0]) pend_m = 0;
            if (base == TX_INT_EN && off + i == 0) inten_m = d[0];
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [1:0] op,
                      input logic [63:0] d);
        addr_i = a; op_size_i = op; write_data_i = d; write_en_i = 1;
        @(posedge clk_i); #1;
        write_en_i = 0;
        model_wr(a, op, d);
        check("wr_no_rv", read_data_v_o, 0);
    endtask

    task automatic rd(input string tag, input logic [15:0] a,
                      input logic [1:0] op, input logic [63:0] exp);
        addr_i = a; op_size_i = op; read_en_i = 1;
        @(posedge clk_i); #1;
        read_en_i = 0;
        check({tag, "_v"}, read_data_v_o, 1);
        check(tag, read_data_o, exp);
        @(posedge clk_i); #1;
        check({tag, "_v0"}, read_data_v_o, 0);
    endtask

    // mode: 0 ready high, 1 ready 1010..., 2 random ready
    task automatic do_send(input int mode, input bit clr_last, input int rst_beat);
        int k, nb, cyc;
        bit done;
        logic [63:0] ed, km;
        logic [7:0] ek;
        nb = (size_m + 7) / 8;
        wr(TX_SEND, 2, 64'($urandom));
        check("load_tvalid", tx_axis_tvalid_o, 0);
        addr_i = TX_READY; op_size_i = 2; read_en_i = 1;
        @(posedge clk_i); #1;
        read_en_i = 0;
        check("busy_rv", read_data_v_o, 1);
        check("busy_ready", read_data_o, 0);
        k = 0; cyc = 0; done = 0;
        while (!done && cyc < 3000) begin
            ed = '0; km = '0; ek = '0;
            for (int b = 0; b < 8; b++) begin
                if (8*k + b < size_m) begin
                    ed[8*b +: 8] = mem_m[8*k + b];
                    km[8*b +: 8] = 8'hFF;
                    ek[b] = 1'b1;
                end
            end
            check("tvalid", tx_axis_tvalid_o, 1);
            check("tdata", tx_axis_tdata_o & km, ed);
            check("tkeep", tx_axis_tkeep_o, ek);
            check("tlast", tx_axis_tlast_o, k == nb - 1);
            case (mode)
                0: tx_axis_tready_i = 1;
                1: tx_axis_tready_i = !cyc[0];
                default: tx_axis_tready_i = 1'($urandom_range(0, 1));
            endcase
            if (rst_beat == k) begin
                reset_i = 1; tx_axis_tready_i = 1;
                @(posedge clk_i); #1;
                reset_i = 0; tx_axis_tready_i = 0;
                size_m = 0; pend_m = 0; inten_m = 0;
                check("rst_tvalid", tx_axis_tvalid_o, 0);
                check("rst_tlast", tx_axis_tlast_o, 0);
                check("rst_irq", tx_interrupt_pending_o, 0);
                return;
            end
            if (tx_axis_tready_i && tx_axis_tvalid_o) begin
                if (k == nb - 1) begin
                    done = 1;
                    if (clr_last) begin
                        addr_i = TX_PENDING; op_size_i = 2;
                        write_data_i = 64'd1; write_en_i = 1;
                    end
                end
                k++;
            end
            @(posedge clk_i); #1;
            tx_axis_tready_i = 0; write_en_i = 0;
            cyc++;
        end
        if (!done) check("send_timeout", 0, 1);
        pend_m = 1;
        check("post_tvalid", tx_axis_tvalid_o, 0);
        check("post_irq", tx_interrupt_pending_o, 64'(pend_m & inten_m));
    endtask

    task automatic fill_words(input int n);
        for (int w = 0; w < n; w++) wr(16'h0800 + 16'(8*w), 3, {$urandom, $urandom});
    endtask

    task automatic no_stream(input string tag);
        for (int i = 0; i < 4; i++) begin
            check(tag, tx_axis_tvalid_o, 0);
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        int nb, sz, op;
        logic [15:0] a;
        reset_i = 1; addr_i = 0; write_en_i = 0; read_en_i = 0;
        op_size_i = 0; write_data_i = 0; tx_axis_tready_i = 0;
        size_m = 0; pend_m = 0; inten_m = 0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_tvalid0", tx_axis_tvalid_o, 0);
        check("rst_tlast0", tx_axis_tlast_o, 0);
        check("rst_tkeep0", tx_axis_tkeep_o, 0);
        check("rst_tdata0", tx_axis_tdata_o, 0);
        check("rst_rv0", read_data_v_o, 0);
        check("rst_rdata0", read_data_o, 0);
        check("rst_irq0", tx_interrupt_pending_o, 0);
        reset_i = 0;
        rd("ready0", TX_READY, 2, 1);
        check("irq_idle", tx_interrupt_pending_o, 0);

        fill_words(8);
        wr(TX_SIZE, 2, 64);
        do_send(0, 0, -1);
        rd("ready_after", TX_READY, 2, 1);
        rd("pend_after", TX_PENDING, 2, 1);
        rd("size_rb", TX_SIZE, 2, 64);
        check("irq_noen", tx_interrupt_pending_o, 0);

        wr(16'h0800, 3, {$urandom, $urandom});
        wr(16'h0808, 2, 64'($urandom));
        wr(16'h080C, 0, 64'($urandom));
        wr(16'h080A, 1, 64'($urandom));
        wr(TX_SIZE, 2, 13);
        do_send(1, 0, -1);
        wr(TX_SIZE + 16'd1, 0, 64'h01);
        rd("size_b1_word", TX_SIZE, 2, 269);
        rd("size_b1_byte", TX_SIZE + 16'd1, 0, 1);

        wr(TX_PENDING, 2, 1);
        rd("pend_clr", TX_PENDING, 2, 0);
        wr(TX_INT_EN, 2, 1);
        fill_words(8);
        wr(TX_SIZE, 2, 64);
        do_send(2, 0, -1);
        check("irq_hi", tx_interrupt_pending_o, 1);
        wr(TX_PENDING, 2, 1);
        check("irq_clr", tx_interrupt_pending_o, 0);
        do_send(0, 1, -1);
        check("irq_setwins", tx_interrupt_pending_o, 1);
        rd("pend_setwins", TX_PENDING, 2, 1);

        wr(TX_SIZE, 2, 0);
        wr(TX_SEND, 2, 1);
        no_stream("size0_tvalid");
        rd("size0_ready", TX_READY, 2, 1);
        wr(TX_SIZE, 2, 2049);
        wr(TX_SEND, 2, 1);
        no_stream("size2049_tvalid");
        rd("size2049_ready", TX_READY, 2, 1);
        wr(16'h0802, 2, 64'($urandom));
        wr(TX_SIZE, 2, 8);
        do_send(2, 0, -1);
        rd("mis_rd", 16'h1029, 1, 0);
        rd("unmapped", 16'h2000, 2, 0);
        rd("buf_rd", 16'h0800, 3, 0);

        addr_i = TX_INT_EN; op_size_i = 2; write_data_i = 0;
        write_en_i = 1; read_en_i = 1;
        @(posedge clk_i); #1;
        write_en_i = 0; read_en_i = 0;
        model_wr(TX_INT_EN, 2, 0);
        check("both_no_rv", read_data_v_o, 0);
        check("both_irq", tx_interrupt_pending_o, 64'(pend_m & inten_m));
        wr(TX_INT_EN, 2, 1);

        for (int it = 0; it < 6; it++) begin
            nb = $urandom_range(1, 32);
            fill_words(nb);
            for (int j = 0; j < 3; j++) begin
                op = $urandom_range(0, 3);
                a = 16'h0800 + 16'($urandom_range(0, nb*8 - 1) & ~((1 << op) - 1));
                wr(a, 2'(op), {$urandom, $urandom});
            end
            sz = $urandom_range(1, nb*8);
            wr(TX_SIZE, 2, 64'(sz));
            do_send(2, 0, -1);
        end

        fill_words(8);
        wr(TX_SIZE, 2, 64);
        do_send(0, 0, 2);
        rd("rst_size", TX_SIZE, 2, 0);
        rd("rst_pend", TX_PENDING, 2, 0);
        rd("rst_ready", TX_READY, 2, 1);
        rd("rst_inten", TX_INT_EN, 2, 0);
        check("rst_irq_end", tx_interrupt_pending_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
